clock_set_cu: RTL and testbench

//  Control unit that sequences time-setting of the clock datapath (hour/min/sec edit).

---
 rtl/clock_set_pkg.sv | 33 +++
 rtl/set_tick_cnt.sv | 34 +++
 rtl/clock_set_cu.sv | 181 ++++++++++++++++++
 tb/tb_clock_set_cu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// Shared types for the clock time-set control unit: FSM state encodings,
// display field codes and a counter-width helper.
package clock_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FLD_NONE = 2'b00,
    FLD_HOUR = 2'b01,
    FLD_MIN  = 2'b10,
    FLD_SEC  = 2'b11
  } field_e;

  // Width of a counter that must hold values 0..max-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int max);
    return (max < 2) ? 1 : $clog2(max);
  endfunction

  function automatic field_e field_of(input state_e st);
    case (st)
      ST_SET_HOUR: return FLD_HOUR;
      ST_SET_MIN:  return FLD_MIN;
      ST_SET_SEC:  return FLD_SEC;
      default:     return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/set_tick_cnt.sv
// Modulo-MAX event counter used for blink half-periods and edit inactivity.
// o_wrap flags the enabled event that returns the count to zero; a clear wins over it.
module set_tick_cnt
  import clock_set_pkg::*;
#(
  parameter int MAX = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap
);

  localparam int W = cnt_width(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en & ~i_clr & (r_cnt == LAST);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (o_wrap) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_cu.sv
// Time-set control unit: walks IDLE->HOUR->MIN->SEC on mode pulses and emits
// registered inc/dec strobes, hold, msec-clear and blink. Optional inactivity
// auto-exit is built when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_cu
  import clock_set_pkg::*;
#(
  parameter int BLINK_TICKS = 50
`ifdef CLOCK_SET_TIMEOUT_EN
  ,
  parameter int TIMEOUT_TICKS = 1000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_clock_mode,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [1:0] o_field,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic       o_inc_sec,
  output logic       o_dec_hour,
  output logic       o_dec_min,
  output logic       o_dec_sec,
  output logic       o_hold,
  output logic       o_msec_clear,
  output logic       o_blink
);

  state_e r_state, w_next;

  logic w_editing;
  logic w_mode_ok;
  logic w_up_ok;
  logic w_down_ok;
  logic w_timeout;
  logic w_blink_clr;
  logic w_blink_en;
  logic w_blink_wrap;

  field_e r_field, w_field_d;
  logic   r_hold, w_hold_d;
  logic   r_msec_clear, w_msec_clear_d;
  logic   r_blink, w_blink_d;
  logic [2:0] r_inc, w_inc_d;  // {hour, min, sec}
  logic [2:0] r_dec, w_dec_d;

  assign w_editing = (r_state != ST_IDLE);
  assign w_mode_ok = i_btn_mode & i_clock_mode;
  // Mode outranks up/down, and up+down together cancel each other.
  assign w_up_ok   = w_editing & i_clock_mode & ~i_btn_mode & i_btn_up & ~i_btn_down;
  assign w_down_ok = w_editing & i_clock_mode & ~i_btn_mode & i_btn_down & ~i_btn_up;

`ifdef CLOCK_SET_TIMEOUT_EN
  logic w_to_clr;
  logic w_to_en;

  assign w_to_clr = i_btn_mode | i_btn_up | i_btn_down | ~w_editing;
  assign w_to_en  = i_tick & w_editing;

  set_tick_cnt #(.MAX(TIMEOUT_TICKS)) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_to_clr),
    .i_en   (w_to_en),
    .o_wrap (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE) begin
      if (w_mode_ok) w_next = ST_SET_HOUR;
    end else if (!i_clock_mode || w_timeout) begin
      w_next = ST_IDLE;
    end else if (i_btn_mode) begin
      case (r_state)
        ST_SET_HOUR: w_next = ST_SET_MIN;
        ST_SET_MIN:  w_next = ST_SET_SEC;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    w_field_d      = field_of(w_next);
    w_hold_d       = (w_next != ST_IDLE);
    w_inc_d        = '0;
    w_dec_d        = '0;
    w_msec_clear_d = 1'b0;
    w_blink_d      = r_blink;

    case (r_state)
      ST_SET_HOUR: begin
        w_inc_d[2] = w_up_ok;
        w_dec_d[2] = w_down_ok;
      end
      ST_SET_MIN: begin
        w_inc_d[1] = w_up_ok;
        w_dec_d[1] = w_down_ok;
      end
      ST_SET_SEC: begin
        w_inc_d[0] = w_up_ok;
        w_dec_d[0] = w_down_ok;
      end
      default: ;
    endcase

    // Leaving SEC by the mode button and an inactivity timeout both finish an
    // edit normally; a mode-switch drop abandons it without touching msec.
    if ((r_state == ST_SET_SEC && w_mode_ok) || (w_editing && i_clock_mode && w_timeout)) begin
      w_msec_clear_d = 1'b1;
    end

    if (w_blink_clr) begin
      w_blink_d = 1'b1;
    end else if (w_blink_wrap) begin
      w_blink_d = ~r_blink;
    end
  end

  // Keep the edited digits visible while they change and outside edit mode.
  assign w_blink_clr = (w_next == ST_IDLE) | (w_next != r_state) | w_up_ok | w_down_ok;
  assign w_blink_en  = i_tick & w_editing;

  set_tick_cnt #(.MAX(BLINK_TICKS)) u_blink_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_blink_clr),
    .i_en   (w_blink_en),
    .o_wrap (w_blink_wrap)
  );

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_field      <= FLD_NONE;
      r_hold       <= 1'b0;
      r_inc        <= '0;
      r_dec        <= '0;
      r_msec_clear <= 1'b0;
      r_blink      <= 1'b1;
    end else begin
      r_field      <= w_field_d;
      r_hold       <= w_hold_d;
      r_inc        <= w_inc_d;
      r_dec        <= w_dec_d;
      r_msec_clear <= w_msec_clear_d;
      r_blink      <= w_blink_d;
    end
  end

  assign o_field      = r_field;
  assign o_hold       = r_hold;
  assign o_inc_hour   = r_inc[2];
  assign o_inc_min    = r_inc[1];
  assign o_inc_sec    = r_inc[0];
  assign o_dec_hour   = r_dec[2];
  assign o_dec_min    = r_dec[1];
  assign o_dec_sec    = r_dec[0];
  assign o_msec_clear = r_msec_clear;
  assign o_blink      = r_blink;

endmodule

// File: tb/tb_clock_set_cu.sv
// Directed bench for clock_set_cu (BLINK_TICKS=4; TIMEOUT_TICKS=10 when
// CLOCK_SET_TIMEOUT_EN is defined).
module tb_clock_set_cu;

  logic       clk;
  logic       reset;
  logic       i_tick;
  logic       i_clock_mode;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
  logic [1:0] o_field;
  logic       o_inc_hour, o_inc_min, o_inc_sec;
  logic       o_dec_hour, o_dec_min, o_dec_sec;
  logic       o_hold;
  logic       o_msec_clear;
  logic       o_blink;
  logic [5:0] strobes;

  int n_pass = 0;
  int n_total = 0;

  clock_set_cu #(
    .BLINK_TICKS(4)
`ifdef CLOCK_SET_TIMEOUT_EN
    ,
    .TIMEOUT_TICKS(10)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_tick       (i_tick),
    .i_clock_mode (i_clock_mode),
    .i_btn_mode   (i_btn_mode),
    .i_btn_up     (i_btn_up),
    .i_btn_down   (i_btn_down),
    .o_field      (o_field),
    .o_inc_hour   (o_inc_hour),
    .o_inc_min    (o_inc_min),
    .o_inc_sec    (o_inc_sec),
    .o_dec_hour   (o_dec_hour),
    .o_dec_min    (o_dec_min),
    .o_dec_sec    (o_dec_sec),
    .o_hold       (o_hold),
    .o_msec_clear (o_msec_clear),
    .o_blink      (o_blink)
  );

  assign strobes = {o_inc_hour, o_inc_min, o_inc_sec, o_dec_hour, o_dec_min, o_dec_sec};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_tick = 1'b0; i_clock_mode = 1'b1;
    i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse_mode();
    i_btn_mode = 1'b1; step(); i_btn_mode = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick = 1'b1; step(); i_tick = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (o_field !== 2'b00) $display("FAIL reset_field got %b want 00", o_field); else n_pass++;
    n_total++; if (o_hold !== 1'b0) $display("FAIL reset_hold got %b want 0", o_hold); else n_pass++;
    n_total++; if (o_blink !== 1'b1) $display("FAIL reset_blink got %b want 1", o_blink); else n_pass++;
    n_total++; if ({strobes, o_msec_clear} !== 7'b0) $display("FAIL reset_strobes got %b want 0000000", {strobes, o_msec_clear}); else n_pass++;
  endtask

  task automatic test_enter_edit();
    do_reset();
    i_btn_mode = 1'b1; step(); i_btn_mode = 1'b0; step();
    n_total++; if (o_field !== 2'b01) $display("FAIL enter_field got %b want 01", o_field); else n_pass++;
    n_total++; if (o_hold !== 1'b1) $display("FAIL enter_hold got %b want 1", o_hold); else n_pass++;
    n_total++; if (o_blink !== 1'b1) $display("FAIL enter_blink got %b want 1", o_blink); else n_pass++;
  endtask

  task automatic test_adjust();
    do_reset();
    pulse_mode(); pulse_mode();
    i_btn_up = 1'b1; step(); i_btn_up = 1'b0;
    n_total++; if (strobes !== 6'b010000) $display("FAIL up_min_strobe got %b want 010000", strobes); else n_pass++;
    step();
    n_total++; if (strobes !== 6'b000000) $display("FAIL up_min_single got %b want 000000", strobes); else n_pass++;
    i_btn_up = 1'b1; i_btn_down = 1'b1; step(); i_btn_up = 1'b0; i_btn_down = 1'b0;
    n_total++; if (strobes !== 6'b000000) $display("FAIL up_down_cancel got %b want 000000", strobes); else n_pass++;
    step();
    i_btn_mode = 1'b1; i_btn_up = 1'b1; step(); i_btn_mode = 1'b0; i_btn_up = 1'b0;
    n_total++; if (strobes !== 6'b000000) $display("FAIL mode_wins_strobe got %b want 000000", strobes); else n_pass++;
    n_total++; if (o_field !== 2'b11) $display("FAIL mode_wins_field got %b want 11", o_field); else n_pass++;
    i_btn_down = 1'b1; step(); i_btn_down = 1'b0;
    n_total++; if (strobes !== 6'b000001) $display("FAIL down_sec_strobe got %b want 000001", strobes); else n_pass++;
    pulse_mode(); step();
    i_btn_up = 1'b1; step(); i_btn_up = 1'b0;
    n_total++; if (strobes !== 6'b000000) $display("FAIL idle_up_strobe got %b want 000000", strobes); else n_pass++;
  endtask

  task automatic test_mode_sequence();
    do_reset();
    pulse_mode();
    n_total++; if (o_field !== 2'b01) $display("FAIL seq_hour got %b want 01", o_field); else n_pass++;
    pulse_mode();
    n_total++; if (o_field !== 2'b10) $display("FAIL seq_min got %b want 10", o_field); else n_pass++;
    pulse_mode();
    n_total++; if ({o_field, o_msec_clear} !== 3'b110) $display("FAIL seq_sec got %b want 110", {o_field, o_msec_clear}); else n_pass++;
    pulse_mode();
    n_total++; if ({o_field, o_hold, o_msec_clear} !== 4'b0001) $display("FAIL seq_exit got %b want 0001", {o_field, o_hold, o_msec_clear}); else n_pass++;
    step();
    n_total++; if (o_msec_clear !== 1'b0) $display("FAIL seq_msec_single got %b want 0", o_msec_clear); else n_pass++;
  endtask

  task automatic test_blink();
    do_reset();
    pulse_mode();
    ticks(3);
    n_total++; if (o_blink !== 1'b1) $display("FAIL blink_t3 got %b want 1", o_blink); else n_pass++;
    ticks(1);
    n_total++; if (o_blink !== 1'b0) $display("FAIL blink_t4 got %b want 0", o_blink); else n_pass++;
    ticks(2);
    i_btn_up = 1'b1; i_btn_down = 1'b1; step(); i_btn_up = 1'b0; i_btn_down = 1'b0; step();
    n_total++; if (o_blink !== 1'b0) $display("FAIL blink_ignored_btn got %b want 0", o_blink); else n_pass++;
    ticks(2);
    n_total++; if (o_blink !== 1'b1) $display("FAIL blink_t8 got %b want 1", o_blink); else n_pass++;
    ticks(4);
    n_total++; if (o_blink !== 1'b0) $display("FAIL blink_t12 got %b want 0", o_blink); else n_pass++;
    i_btn_up = 1'b1; step(); i_btn_up = 1'b0;
    n_total++; if ({o_blink, strobes} !== 7'b1100000) $display("FAIL blink_up_force got %b want 1100000", {o_blink, strobes}); else n_pass++;
    step();
    ticks(3);
    n_total++; if (o_blink !== 1'b1) $display("FAIL blink_after_up_t3 got %b want 1", o_blink); else n_pass++;
    ticks(1);
    n_total++; if (o_blink !== 1'b0) $display("FAIL blink_after_up_t4 got %b want 0", o_blink); else n_pass++;
  endtask

  task automatic test_clock_mode_drop();
    do_reset();
    pulse_mode(); pulse_mode(); pulse_mode();
    i_clock_mode = 1'b0; i_btn_up = 1'b1; step(); i_btn_up = 1'b0;
    n_total++; if ({o_field, o_hold, o_msec_clear} !== 4'b0000) $display("FAIL drop_exit got %b want 0000", {o_field, o_hold, o_msec_clear}); else n_pass++;
    n_total++; if (strobes !== 6'b000000) $display("FAIL drop_strobe got %b want 000000", strobes); else n_pass++;
    pulse_mode(); step();
    n_total++; if ({o_field, o_hold} !== 3'b000) $display("FAIL drop_mode_ignored got %b want 000", {o_field, o_hold}); else n_pass++;
    i_clock_mode = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_mode(); pulse_mode();
`ifdef CLOCK_SET_TIMEOUT_EN
    ticks(9);
    n_total++; if (o_field !== 2'b10) $display("FAIL timeout_t9 got %b want 10", o_field); else n_pass++;
    i_tick = 1'b1; step(); i_tick = 1'b0;
    n_total++; if ({o_field, o_hold, o_msec_clear} !== 4'b0001) $display("FAIL timeout_exit got %b want 0001", {o_field, o_hold, o_msec_clear}); else n_pass++;
    step();
    n_total++; if (o_msec_clear !== 1'b0) $display("FAIL timeout_msec_single got %b want 0", o_msec_clear); else n_pass++;
`else
    ticks(12);
    n_total++; if (o_field !== 2'b10) $display("FAIL no_timeout got %b want 10", o_field); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    pulse_mode();
    i_btn_up = 1'b1; reset = 1'b1; step(); i_btn_up = 1'b0; reset = 1'b0;
    n_total++; if ({o_field, o_hold, o_blink} !== 4'b0001) $display("FAIL midreset_state got %b want 0001", {o_field, o_hold, o_blink}); else n_pass++;
    n_total++; if (strobes !== 6'b000000) $display("FAIL midreset_strobe got %b want 000000", strobes); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_enter_edit();
    test_adjust();
    test_mode_sequence();
    test_blink();
    test_clock_mode_drop();
    test_timeout();
    test_reset_mid_edit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
